// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//    Shares one single-port 256x32 synchronous data memory between two
//    requesters: port A (instruction fetch) and port B (load/store).  Each
//    access is a three-cycle transaction: IDLE (grant), ACCESS (memory
//    samples), RESP (done and read data).  The arbiter owns the memory
//    control lines.  It keeps mem_rw at 1 (read) in every cycle except the
//    ACCESS cycle of a write, so an idle or reset memory is never written.
//
// Configuration:
//    MEM_ARB_FIXED_PRIO_EN  defined   : port A always wins simultaneous
//                                       requests.
//                           undefined : round-robin.  The port that was not
//                                       served last wins a tie.
//
// Ports:
//    clk, rst_n                 clock (rising edge), async active-low reset
//    a_req/a_we/a_addr/a_wdata  port A request (held stable until a_gnt)
//    a_gnt                      port A accept pulse (combinational, IDLE)
//    a_done/a_rdata             port A completion pulse and read data
//    b_*                        same set for port B
//    mem_addr/mem_din/mem_rw    memory address, write data, R_W (1 = read)
//    mem_dout                   registered memory read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_USED = 8,
   parameter int DW        = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [31:0]   a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_done,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [31:0]   b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_done,
   output logic [DW-1:0] b_rdata,
   output logic [31:0]   mem_addr,
   output logic [DW-1:0] mem_din,
   output logic          mem_rw,
   input  logic [DW-1:0] mem_dout
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   // Keeps only the low ADDR_USED bits of a requester address.
   localparam logic [31:0] ADDR_MASK = (ADDR_USED >= 32) ? 32'hFFFF_FFFF
                                       : ((32'd1 << ADDR_USED) - 32'd1);

   logic [1:0]    state_r;
   logic          win_b_r;      // 1 = current transaction belongs to port B
   logic          we_r;         // current transaction is a write
   logic          sel_b_s;      // arbitration result: 1 = B wins
   logic          grant_s;
   logic          resp_s;
   logic          win_we_s;
   logic [31:0]   win_addr_s;
   logic [DW-1:0] win_wdata_s;
`ifndef MEM_ARB_FIXED_PRIO_EN
   logic          last_b_r;     // 1 = port B was served last
`endif

   // Arbitration: a single requester wins; a tie is broken by priority mode.
   always_comb begin
      sel_b_s = 1'b0;
      if (a_req && b_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         sel_b_s = 1'b0;
`else
         sel_b_s = ~last_b_r;
`endif
      end else if (b_req) begin
         sel_b_s = 1'b1;
      end else begin
         sel_b_s = 1'b0;
      end
   end

   // Winner request mux feeding the memory control registers.
   always_comb begin
      win_we_s    = 1'b0;
      win_addr_s  = 32'h0000_0000;
      win_wdata_s = {DW{1'b0}};
      if (sel_b_s) begin
         win_we_s    = b_we;
         win_addr_s  = b_addr;
         win_wdata_s = b_wdata;
      end else begin
         win_we_s    = a_we;
         win_addr_s  = a_addr;
         win_wdata_s = a_wdata;
      end
   end

   // Grants exist only in IDLE and never while reset is asserted.
   assign grant_s = rst_n && (state_r == ST_IDLE) && (a_req || b_req);
   assign a_gnt   = grant_s & ~sel_b_s;
   assign b_gnt   = grant_s &  sel_b_s;

   // Done and read data come from registered state.  mem_dout already holds
   // the word sampled on the edge that ended ACCESS.
   assign resp_s  = (state_r == ST_RESP);
   assign a_done  = resp_s & ~win_b_r;
   assign b_done  = resp_s &  win_b_r;
   assign a_rdata = (a_done && !we_r) ? mem_dout : {DW{1'b0}};
   assign b_rdata = (b_done && !we_r) ? mem_dout : {DW{1'b0}};

   // Transaction FSM and memory control registers.  Reset forces
   // mem_rw to 1 asynchronously, which suppresses a write that is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         mem_rw   <= 1'b1;
         mem_addr <= 32'h0000_0000;
         mem_din  <= {DW{1'b0}};
         win_b_r  <= 1'b0;
         we_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_s) begin
                  mem_addr <= win_addr_s & ADDR_MASK;
                  mem_din  <= win_wdata_s;
                  mem_rw   <= ~win_we_s;
                  win_b_r  <= sel_b_s;
                  we_r     <= win_we_s;
                  state_r  <= ST_ACCESS;
               end else begin
                  mem_rw   <= 1'b1;
               end
            end
            ST_ACCESS: begin
               mem_rw  <= 1'b1;
               state_r <= ST_RESP;
            end
            ST_RESP: begin
               mem_rw  <= 1'b1;
               state_r <= ST_IDLE;
            end
            default: begin
               mem_rw  <= 1'b1;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifndef MEM_ARB_FIXED_PRIO_EN
   // Round-robin history.  After reset it points at B, so A wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_b_r <= 1'b1;
      end else if (grant_s) begin
         last_b_r <= sel_b_s;
      end else begin
         last_b_r <= last_b_r;
      end
   end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 256x32 synchronous data memory (R_W: 1 = read, 0 = write, registered DataOut) between two requesters.
- Port A is instruction fetch; port B is load/store.
- Round-robin arbitration with a req/gnt/done handshake.
- Owns the memory control lines and holds the memory in read mode whenever it is not writing, so no idle cycle can corrupt memory contents.

Parameters:
- ADDR_USED, 8, number of low address bits forwarded to memory (upper bits zeroed).
- DW, 32, data word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  port A request; held with a_we/a_addr/a_wdata stable until a_gnt.
- a_we  input  1  1 = write, 0 = read.
- a_addr  input  32  byte-free word address.
- a_wdata  input  DW  write data.
- a_gnt  output  1  one-cycle accept pulse (combinational, IDLE only).
- a_done  output  1  one-cycle completion pulse.
- a_rdata  output  DW  read data, valid only while a_done is high and the access was a read.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: same as port A, for port B.
- mem_addr  output  32  to memory address; {zeros, addr[ADDR_USED-1:0]}.
- mem_din  output  DW  to memory DataIn.
- mem_rw  output  1  to memory R_W.
- mem_dout  input  DW  from memory DataOut.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, mem_rw=1, mem_addr=0, mem_din=0.
  - a_done=b_done=0, a_gnt=b_gnt=0, a_rdata=b_rdata=0.
  - last_served=B, so A wins the first tie.
- FSM states:
  - IDLE:
    - If any req, select a winner and pulse its gnt combinationally in this cycle (cycle N).
    - On the edge ending N: register mem_addr/mem_din from the winner, set mem_rw = ~we, latch winner id and we, go to ACCESS.
    - No req: stay in IDLE, mem_rw=1.
  - ACCESS (cycle N+1): memory samples on the edge ending N+1. Go to RESP. On that edge mem_rw returns to 1.
  - RESP (cycle N+2):
    - Pulse winner's done.
    - For a read, winner's rdata = mem_dout in this cycle.
    - Non-winner's rdata = 0.
    - Return to IDLE.
- Latency/throughput:
  - gnt at N, done at N+2.
  - Minimum spacing between grants is 3 cycles; there is no grant in ACCESS or RESP.
- Arbitration:
  - Single req: that port wins.
  - Both req: the port not equal to last_served wins.
  - last_served updates on grant.
- mem_rw=0 only during ACCESS of a write; 1 in every other cycle.
- The loser of a simultaneous request must keep req asserted; it is granted in the next IDLE.
- A req deasserted before gnt is ignored and has no effect.
- Address: bits [31:ADDR_USED] of the requester address are discarded. Example: address 0x0000_0105 maps to memory row 0x05.
- Reset mid-operation:
  - Transaction is aborted; no done pulse.
  - mem_rw is forced to 1 asynchronously, so a write in ACCESS is suppressed if reset is asserted before the sampling edge.
- done and gnt are never asserted to both ports in the same cycle.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port A always wins simultaneous requests and last_served is unused. B may starve; this is acceptable for the single-cycle-fetch configuration.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset, then A write addr 0x10 data 0xDEADBEEF:
  - a_gnt at N; mem_rw=0 only in N+1; a_done at N+2.
  - Then A read 0x10: a_done at N'+2 with a_rdata=0xDEADBEEF.
- A and B both request reads in the same cycle right after reset:
  - A granted first; B granted at the next IDLE, 3 cycles later.
  - Repeat with both held: grants alternate B, A, B.
  - With MEM_ARB_FIXED_PRIO_EN defined: A every time.
- B write addr 0x0000_0123 data 0x55:
  - Memory row 0x23 written.
  - A read 0x23 returns 0x55.
- Idle for 20 cycles with no req:
  - mem_rw=1 in every cycle.
  - Previously written rows are unchanged on readback.
- Assert rst_n=0 during ACCESS of a B write to 0x40 (prior content 0x1):
  - mem_rw goes to 1 immediately; no b_done.
  - After reset, read 0x40 returns 0x1.
- B read to 0x08 while A deasserts a_req before gnt:
  - Only B is granted.
  - a_done stays 0 throughout.
